psu_tach_monitor: RTL and testbench
===================================

// Module: psu_tach_monitor
// PURPOSE
//   Measures the PSU1 fan tachometer and drives PSU1_Tach_Low/PSU1_Tach_High into the LED block's PSU1 colour logic.
//   Runs on SlowClock (32,768 Hz) with the shared Strobe16ms tick.
//   Synchronises and glitch-filters the raw tach, counts pulses per measurement window, and reports out-of-range speed.
//   Out-of-range is qualified over several windows.
// PARAMETERS
//   WINDOW_STROBES  64   Strobe16ms pulses per measurement window (~1.024 s)
//   CNT_W           8    pulse counter width; count saturates at 2^CNT_W-1
//   LOW_LIMIT       20   window count < LOW_LIMIT is a low-speed window
//   HIGH_LIMIT      200  window count > HIGH_LIMIT is an overspeed window; must be < 2^CNT_W-1
//   FAIL_WINDOWS    3    consecutive bad windows needed to assert a flag
//   SETTLE_WINDOWS  2    windows discarded after power-on
// PORTS
//   SlowClock       in   1      32,768 Hz clock
//   Reset_N         in   1      asynchronous active-low reset
//   Strobe16ms      in   1      single-SlowClock pulse every 16 ms
//   FM_PS_EN        in   1      power switch; monitor runs only when == `PwrSW_On
//   PSU1_TACH       in   1      raw asynchronous tach, 2 pulses/rev
//   PSU1_Tach_Low   out  1      1 = fan too slow or stopped
//   PSU1_Tach_High  out  1      1 = fan overspeed
//   TachCount       out  CNT_W  pulse count of last completed window
//   TachValid       out  1      1 = TachCount holds a MONITOR-state window
// BEHAVIOUR
//   Interface: one clock (SlowClock); reset Reset_N is asynchronous and active-low.
//   Reset: all outputs 0; FSM = OFF; all counters and filters 0.
//   Input path
//     - 2-flop synchroniser, then 3-sample filter.
//     - Filtered level changes only after 3 consecutive equal samples.
//     - Rising edge of the filtered level = 1 pulse.
//     - Edge latency: 5 clocks from the raw edge to the count increment.
//   Window
//     - Window counter increments on Strobe16ms.
//     - On the WINDOW_STROBES-th strobe (window end), the pulse count is latched to TachCount and the counter clears.
//     - The pulse counter saturates at 2^CNT_W-1 and never wraps.
//     - A pulse coinciding with window end counts in the new window, which starts at 1.
//   Classification at window end: bad_low = cnt<LOW_LIMIT; bad_high = cnt>HIGH_LIMIT.
//     - Separate consecutive-bad counters for low and high, each saturating at FAIL_WINDOWS.
//     - A good window, or a bad window of the other kind, clears that counter.
//     - A flag asserts the clock after its counter reaches FAIL_WINDOWS.
//     - The two flags are never both 1.
//   FSM
//     - OFF: counters held at 0; flags, TachValid = 0.
//       Goes to SETTLE when FM_PS_EN==`PwrSW_On; the window starts at the next strobe.
//     - SETTLE: windows run and TachCount updates; TachValid = 0; no classification.
//       Goes to MONITOR after SETTLE_WINDOWS window ends.
//     - MONITOR: classification active; TachValid = 1 from the first window end.
//     - Any state: FM_PS_EN != `PwrSW_On goes to OFF next clock.
//       Flags, TachValid and the window/pulse/bad counters clear that clock; TachCount holds.
//   Power loss mid-window: the partial window is discarded, with no classification.
// CONFIGURATION
//   PSU_TACH_LATCH_EN defined
//     - Adds input TachClr (1 bit, single-clock pulse).
//     - Asserted flags are sticky until a TachClr pulse or OFF.
//     - TachClr clears both flags and both bad counters.
//     - TachClr coinciding with the window end that would assert a flag: the set wins.
//   PSU_TACH_LATCH_EN undefined
//     - No TachClr port.
//     - A flag deasserts on the first window end classified not-bad for that flag.
// TESTING (defaults; strobe every 524 clocks)
//   - Reset release, FM_PS_EN on, 100 pulses/window -> TachValid=1 after window 3;
//     TachCount=100; both flags stay 0.
//   - Tach stuck low in MONITOR -> TachCount=0 each window;
//     PSU1_Tach_Low=1 only after the 3rd bad window, not the 2nd.
//   - 2 bad windows (10), 1 good (100), 2 bad (10) -> PSU1_Tach_Low stays 0.
//   - 300 pulses/window -> TachCount=255 (saturated); PSU1_Tach_High=1 after 3 windows;
//     PSU1_Tach_Low=0.
//   - 1-clock and 2-clock raw glitches at 100/window plus 50 real pulses -> TachCount=50.
//   - Flag asserted, FM_PS_EN off mid-window -> flags and TachValid 0 next clock.
//     Re-enable: 2 settle windows, no flags.
//     With PSU_TACH_LATCH_EN: flag holds over good windows until TachClr.

Source files
------------

// File: rtl/psu_tach_monitor.sv
// psu_tach_monitor: PSU1 tach filter, windowed pulse count and low/high speed flags.
// Define PSU_TACH_LATCH_EN for sticky flags cleared by a TachClr pulse.
`ifndef PwrSW_On
`define PwrSW_On 1'b1
`endif
module psu_tach_monitor #(
  parameter int WINDOW_STROBES = 64,
  parameter int CNT_W          = 8,
  parameter int LOW_LIMIT      = 20,
  parameter int HIGH_LIMIT     = 200,
  parameter int FAIL_WINDOWS   = 3,
  parameter int SETTLE_WINDOWS = 2
) (
  input  logic             SlowClock,
  input  logic             Reset_N,
  input  logic             Strobe16ms,
  input  logic             FM_PS_EN,
  input  logic             PSU1_TACH,
`ifdef PSU_TACH_LATCH_EN
  input  logic             TachClr,
`endif
  output logic             PSU1_Tach_Low,
  output logic             PSU1_Tach_High,
  output logic [CNT_W-1:0] TachCount,
  output logic             TachValid
);
  localparam int WIN_W = $clog2(WINDOW_STROBES + 1);
  localparam int BAD_W = $clog2(FAIL_WINDOWS + 1);
  localparam int SET_W = $clog2(SETTLE_WINDOWS + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_STROBES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] LO_LIM   = CNT_W'(LOW_LIMIT);
  localparam logic [CNT_W-1:0] HI_LIM   = CNT_W'(HIGH_LIMIT);
  localparam logic [BAD_W-1:0] BAD_MAX  = BAD_W'(FAIL_WINDOWS);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_WINDOWS - 1);
`ifdef PSU_TACH_LATCH_EN
  localparam logic LATCH = 1'b1;
`else
  localparam logic LATCH = 1'b0;
`endif

  typedef enum logic [1:0] {OFF, SETTLE, MONITOR} state_t;

  state_t             state_q, state_d;
  logic [1:0]         sync_q, filt_q;
  logic               lvl_q, lvl_d, run_q, run_d, valid_q, valid_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, count_q, count_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [BAD_W-1:0]   lo_bad_q, lo_bad_d, hi_bad_q, hi_bad_d;
  logic               lo_flag_q, lo_flag_d, hi_flag_q, hi_flag_d;
  logic               en, active, all_hi, all_lo, pulse, win_end, settle_end, mon_end, clr;

`ifdef PSU_TACH_LATCH_EN
  assign clr = TachClr;
`else
  assign clr = 1'b0;
`endif

  assign en         = FM_PS_EN == `PwrSW_On;
  assign active     = en && state_q != OFF;
  assign all_hi     = &{filt_q, sync_q[1]};
  assign all_lo     = ~|{filt_q, sync_q[1]};
  assign pulse      = all_hi & ~lvl_q;
  assign win_end    = active & run_q & Strobe16ms & (win_q == WIN_LAST);
  assign settle_end = win_end & (state_q == SETTLE);
  assign mon_end    = win_end & (state_q == MONITOR);

  // A pulse landing on the window-end clock opens the next window at 1.
  always_comb begin
    state_d   = !en ? OFF : (state_q == OFF) ? SETTLE :
                (settle_end && settle_q == SET_LAST) ? MONITOR : state_q;
    lvl_d     = all_hi | (lvl_q & ~all_lo);
    run_d     = active & (run_q | Strobe16ms);
    win_d     = (!active || !run_q || win_end) ? '0 : win_q + WIN_W'(Strobe16ms);
    cnt_d     = (!active || !run_q) ? '0 : win_end ? CNT_W'(pulse) :
                cnt_q + CNT_W'(pulse && cnt_q != CNT_MAX);
    count_d   = win_end ? cnt_q : count_q;
    settle_d  = !active ? '0 : settle_end ? settle_q + 1'b1 : settle_q;
    lo_bad_d  = !active ? '0 : mon_end ? ((cnt_q < LO_LIM) ? lo_bad_q + BAD_W'(lo_bad_q != BAD_MAX) : '0) :
                clr ? '0 : lo_bad_q;
    hi_bad_d  = !active ? '0 : mon_end ? ((cnt_q > HI_LIM) ? hi_bad_q + BAD_W'(hi_bad_q != BAD_MAX) : '0) :
                clr ? '0 : hi_bad_q;
    lo_flag_d = active & ~clr & ((lo_bad_q == BAD_MAX) | (LATCH & lo_flag_q & (hi_bad_q != BAD_MAX)));
    hi_flag_d = active & ~clr & ((hi_bad_q == BAD_MAX) | (LATCH & hi_flag_q & (lo_bad_q != BAD_MAX)));
    valid_d   = active & (valid_q | mon_end);
  end

  always_ff @(posedge SlowClock or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q   <= OFF;
      sync_q    <= '0;
      filt_q    <= '0;
      lvl_q     <= 1'b0;
      run_q     <= 1'b0;
      win_q     <= '0;
      cnt_q     <= '0;
      count_q   <= '0;
      settle_q  <= '0;
      lo_bad_q  <= '0;
      hi_bad_q  <= '0;
      lo_flag_q <= 1'b0;
      hi_flag_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[0], PSU1_TACH};
      filt_q    <= {filt_q[0], sync_q[1]};
      lvl_q     <= lvl_d;
      run_q     <= run_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      count_q   <= count_d;
      settle_q  <= settle_d;
      lo_bad_q  <= lo_bad_d;
      hi_bad_q  <= hi_bad_d;
      lo_flag_q <= lo_flag_d;
      hi_flag_q <= hi_flag_d;
      valid_q   <= valid_d;
    end
  end

  assign PSU1_Tach_Low  = lo_flag_q;
  assign PSU1_Tach_High = hi_flag_q;
  assign TachCount      = count_q;
  assign TachValid      = valid_q;
endmodule

// File: tb/tb_psu_tach_monitor.sv
// tb_psu_tach_monitor: scoreboard bench for psu_tach_monitor using an 8-strobe window.
`timescale 1ns/1ps
`ifndef PwrSW_On
`define PwrSW_On 1'b1
`endif
module tb_psu_tach_monitor;
  localparam int WS = 8;
  localparam int SP = 350;
  localparam logic ON = `PwrSW_On;

  logic clk = 1'b0, rst_n = 1'b0, strobe = 1'b0, en = ~ON, tach = 1'b0, clr = 1'b0;
  logic low, high, valid;
  logic [7:0] count;
  int errors = 0, checks = 0;

  typedef struct {int cnt; bit v; bit lo; bit hi;} exp_t;
  exp_t sb[$];
  int m_win = 0, m_lo = 0, m_hi = 0, m_count = 0;
  bit m_flo = 0, m_fhi = 0, m_valid = 0;
  event win_ev;

  always #5 clk = ~clk;

  psu_tach_monitor #(.WINDOW_STROBES(WS)) dut (
    .SlowClock(clk), .Reset_N(rst_n), .Strobe16ms(strobe), .FM_PS_EN(en), .PSU1_TACH(tach),
`ifdef PSU_TACH_LATCH_EN
    .TachClr(clr),
`endif
    .PSU1_Tach_Low(low), .PSU1_Tach_High(high), .TachCount(count), .TachValid(valid));

  // Real pulses: 4 high / 3 low from t=20; glitches of 1 or 2 clocks every 10 from t=400.
  function automatic logic tach_at(int t, int np, int ng);
    if (t >= 20 && t < 20 + 7 * np && (t - 20) % 7 < 4) return 1'b1;
    if (t >= 400 && t < 400 + 10 * ng) return ((t - 400) % 10) < (((t - 400) / 10) % 2 + 1);
    return 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_window(input int np, input int ng, input int ns);
    for (int t = 0; t < ns * SP; t++) begin
      strobe = (t % SP == SP - 1);
      tach = tach_at(t, np, ng);
      tick();
    end
    strobe = 1'b0;
    tach = 1'b0;
  endtask

  task automatic predict(input int np);
    exp_t e;
    int c;
    c = np > 255 ? 255 : np;
    m_count = c;
    if (m_win >= 2) begin
      m_valid = 1;
      if (c < 20) begin m_lo = m_lo < 3 ? m_lo + 1 : 3; m_hi = 0; end
      else if (c > 200) begin m_hi = m_hi < 3 ? m_hi + 1 : 3; m_lo = 0; end
      else begin m_lo = 0; m_hi = 0; end
`ifdef PSU_TACH_LATCH_EN
      if (m_lo == 3) begin m_flo = 1; m_fhi = 0; end
      if (m_hi == 3) begin m_fhi = 1; m_flo = 0; end
`else
      m_flo = (m_lo == 3);
      m_fhi = (m_hi == 3);
`endif
    end
    m_win++;
    e.cnt = c; e.v = m_valid; e.lo = m_flo; e.hi = m_fhi;
    sb.push_back(e);
  endtask

  task automatic run_window(input int np, input int ng);
    predict(np);
    drive_window(np, ng, WS);
    tick();
    tick();
    ->win_ev;
    tick();
  endtask

  task automatic start_monitor();
    en = ON;
    repeat (3) tick();
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    repeat (5) tick();
  endtask

  initial forever begin
    @(win_ev);
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL sb_underflow: window ended with no expected entry");
    end else begin
      exp_t e;
      e = sb.pop_front();
      checks += 4;
      if (count !== 8'(e.cnt)) begin errors++; $display("FAIL win_count: got %0d want %0d", count, e.cnt); end
      if (valid !== e.v) begin errors++; $display("FAIL win_valid: got %b want %b", valid, e.v); end
      if (low !== e.lo) begin errors++; $display("FAIL win_low: got %b want %b", low, e.lo); end
      if (high !== e.hi) begin errors++; $display("FAIL win_high: got %b want %b", high, e.hi); end
    end
  end

  task automatic test_reset();
    repeat (3) tick();
    checks += 4;
    if (count !== 8'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", count); end
    if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", valid); end
    if (low !== 1'b0) begin errors++; $display("FAIL rst_low: got %b want 0", low); end
    if (high !== 1'b0) begin errors++; $display("FAIL rst_high: got %b want 0", high); end
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin tach = (i % 8) < 4; tick(); end
    tach = 1'b0;
    checks += 2;
    if (valid !== 1'b0) begin errors++; $display("FAIL off_valid: got %b want 0", valid); end
    if (count !== 8'd0) begin errors++; $display("FAIL off_count: got %0d want 0", count); end
  endtask

  task automatic test_nominal();
    start_monitor();
    repeat (3) run_window(100, 0);
  endtask

  task automatic test_stuck_low();
    repeat (2) run_window(0, 0);
    predict(0);
    drive_window(0, 0, WS);
    checks++;
    if (low !== 1'b0) begin errors++; $display("FAIL low_early: got %b want 0", low); end
    tick();
    checks++;
    if (low !== 1'b1) begin errors++; $display("FAIL low_set: got %b want 1", low); end
    tick();
    ->win_ev;
    tick();
    run_window(100, 0);
`ifdef PSU_TACH_LATCH_EN
    clr = 1'b1;
    tick();
    clr = 1'b0;
    m_flo = 0; m_fhi = 0; m_lo = 0; m_hi = 0;
    checks++;
    if (low !== 1'b0) begin errors++; $display("FAIL clr_low: got %b want 0", low); end
`endif
  endtask

  task automatic test_pattern();
    int pat[5] = '{10, 10, 100, 10, 10};
    foreach (pat[i]) run_window(pat[i], 0);
  endtask

  task automatic test_glitch();
    run_window(50, 100);
  endtask

  task automatic test_overspeed();
    repeat (3) run_window(300, 0);
  endtask

  task automatic test_power_off();
    drive_window(100, 0, WS / 2);
    checks++;
    if (high !== m_fhi) begin errors++; $display("FAIL pre_off_high: got %b want %b", high, m_fhi); end
    en = ~ON;
    tick();
    checks += 4;
    if (high !== 1'b0) begin errors++; $display("FAIL off_high: got %b want 0", high); end
    if (low !== 1'b0) begin errors++; $display("FAIL off_low: got %b want 0", low); end
    if (valid !== 1'b0) begin errors++; $display("FAIL off_valid2: got %b want 0", valid); end
    if (count !== 8'(m_count)) begin errors++; $display("FAIL off_count_hold: got %0d want %0d", count, m_count); end
    m_win = 0; m_lo = 0; m_hi = 0; m_flo = 0; m_fhi = 0; m_valid = 0;
    repeat (20) tick();
    start_monitor();
    repeat (3) run_window(100, 0);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stuck_low();
    test_pattern();
    test_glitch();
    test_overspeed();
    test_power_off();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d entries want 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
